// File: rtl/irq_encoder_pkg.sv
// ============================================================================
//  Module   : irq_encoder_pkg
//  Purpose  : Interrupt code constants and helpers shared with the vector decoder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package irq_encoder_pkg;

    localparam int         NUM_SRC  = 3;
    localparam logic [1:0] IRQ_NONE = 2'b00;
    localparam logic [1:0] IRQ_1    = 2'b01;
    localparam logic [1:0] IRQ_2    = 2'b10;
    localparam logic [1:0] IRQ_3    = 2'b11;

    // Index of the highest set source bit (bit i-1 = source i), IRQ_NONE if empty.
    function automatic logic [1:0] highest_src(input logic [NUM_SRC-1:0] v);
        highest_src = IRQ_NONE;
        if (v[0]) highest_src = IRQ_1;
        if (v[1]) highest_src = IRQ_2;
        if (v[2]) highest_src = IRQ_3;
    endfunction

    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [1:0] code);
        case (code)
            IRQ_1:   src_onehot = 3'b001;
            IRQ_2:   src_onehot = 3'b010;
            IRQ_3:   src_onehot = 3'b100;
            default: src_onehot = 3'b000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// ============================================================================
//  Module   : irq_sync_edge
//  Purpose  : Optional two-flop synchroniser, delay flop and rising-edge pulse.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module irq_sync_edge #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_edge
);

    logic w_synced;
    logic r_dly_q;

    generate
        if (SYNC_EN) begin : g_sync
            logic r_meta_q;
            logic r_sync_q;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_meta_q <= 1'b0;
                    r_sync_q <= 1'b0;
                end else begin
                    r_meta_q <= i_line;
                    r_sync_q <= r_meta_q;
                end
            end

            assign w_synced = r_sync_q;
        end else begin : g_bypass
            assign w_synced = i_line;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dly_q <= 1'b0;
        end else begin
            r_dly_q <= w_synced;
        end
    end

    assign o_edge = w_synced & ~r_dly_q;

endmodule

`default_nettype wire

// File: rtl/irq_encoder.sv
// ============================================================================
//  Module   : irq_encoder
//  Purpose  : Pending/mask/in-service tracking with nested fixed-priority encode.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module irq_encoder
    import irq_encoder_pkg::*;
#(
    parameter bit                 SYNC_EN  = 1'b1,
    parameter logic [NUM_SRC-1:0] MASK_RST = 3'b000
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [NUM_SRC-1:0] in_irq,
    input  logic               in_ie,
    input  logic               in_mask_we,
    input  logic [NUM_SRC-1:0] in_mask,
    input  logic               in_ack,
    input  logic               in_eret,
    output logic               out_req,
    output logic [1:0]         out_code,
    output logic [NUM_SRC-1:0] out_pending,
    output logic [1:0]         out_level
);

    logic [NUM_SRC-1:0] w_edge;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_sync_edge #(
                .SYNC_EN (SYNC_EN)
            ) u_sync_edge (
                .i_clk  (in_clk),
                .i_rst  (in_rst),
                .i_line (in_irq[gi]),
                .o_edge (w_edge[gi])
            );
        end
    endgenerate

    logic [NUM_SRC-1:0] r_pend_q, w_pend_d;
    logic [NUM_SRC-1:0] r_isr_q,  w_isr_d;
    logic [NUM_SRC-1:0] r_mask_q, w_mask_d;

    logic [1:0]         w_level;
    logic [1:0]         w_cand;
    logic               w_req;
    logic [1:0]         w_code;
    logic [NUM_SRC-1:0] w_ack_bit;
    logic [NUM_SRC-1:0] w_eret_bit;

    always_comb begin
        w_level = highest_src(r_isr_q);
        w_cand  = highest_src(r_pend_q & ~r_mask_q);
        // Only a strictly higher level may preempt the handler in service.
        w_req   = in_ie && (w_cand != IRQ_NONE) && (w_cand > w_level);
        w_code  = w_req ? w_cand : IRQ_NONE;

        w_ack_bit  = (in_ack && w_req) ? src_onehot(w_code) : '0;
        w_eret_bit = in_eret ? src_onehot(w_level) : '0;

        // Edge set beats ack clear; eret acts on the pre-ack in-service set.
        w_pend_d = (r_pend_q & ~w_ack_bit) | w_edge;
        w_isr_d  = (r_isr_q & ~w_eret_bit) | w_ack_bit;
        w_mask_d = in_mask_we ? in_mask : r_mask_q;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_pend_q <= '0;
            r_isr_q  <= '0;
            r_mask_q <= MASK_RST;
        end else begin
            r_pend_q <= w_pend_d;
            r_isr_q  <= w_isr_d;
            r_mask_q <= w_mask_d;
        end
    end

    assign out_req     = w_req;
    assign out_code    = w_code;
    assign out_pending = r_pend_q;
    assign out_level   = w_level;

endmodule

`default_nettype wire

// File: doc/irq_encoder.md
# irq_encoder

Interrupt request encoder for the CPU's interrupt path. It synchronises and edge-detects three external request lines and holds them as pending interrupts. It applies a mask and nested-priority rules, and presents the winning source as a 2-bit interrupt code. The vector decoder downstream turns that code into the handler address. Each CPU-side acknowledge marks one level in service, and each return-from-interrupt retires one level.

## Interface
- `SYNC_EN`, default 1: 1 = two-flop synchroniser on each `in_irq` line; 0 = lines already synchronous, synchroniser bypassed (latency drops by 2).
- `MASK_RST`, default 3'b000: reset value of the mask register (bit set = source masked).

- `in_clk`  input  1  single clock; all state changes on its rising edge.
- `in_rst`  input  1  synchronous, active-high reset.
- `in_irq`  input  3  raw request lines; bit i-1 = source i (i = 1..3); a rising edge raises a request.
- `in_ie`  input  1  global interrupt enable from the CPU.
- `in_mask_we`  input  1  write strobe for the mask register.
- `in_mask`  input  3  new mask value, captured when `in_mask_we`=1.
- `in_ack`  input  1  CPU accepts the current `out_code` (one-cycle pulse).
- `in_eret`  input  1  CPU returns from its current handler (one-cycle pulse).
- `out_req`  output  1  interrupt request to the CPU.
- `out_code`  output  2  code of the winning source; 2'b00 = none.
- `out_pending`  output  3  pending register, for debug display.
- `out_level`  output  2  highest in-service level; 0 = none.

## Operation
- Per-source path: optional 2-flop synchroniser, then a delay flop. Edge = synced & ~delayed.
- `pend[i]` is set on an edge and cleared by `in_ack` when `out_code`==i.
  - Set wins over clear in the same cycle.
  - Masked sources still latch pending and keep it.
- `isr[3:1]` is the in-service register. `out_level` = index of the highest set bit of `isr`, or 0 if none.
- Candidate = highest i with `pend[i]` & ~`mask[i]`. Priority is fixed: 3 > 2 > 1.
- `out_req` = `in_ie` & candidate exists & candidate > `out_level` (nested preemption by strictly higher levels only).
- `out_code` = candidate when `out_req`, else 2'b00.
- `in_ack` with `out_req`=1 sets `isr[out_code]` and clears `pend[out_code]`. `in_ack` with `out_req`=0 is ignored.
- `in_eret` clears the highest set bit of `isr`. With `isr` empty it is a no-op.
- `in_ack` and `in_eret` in the same cycle: the eret clear applies to the pre-ack `isr`, then the ack bit is set.
- `in_mask_we`: the mask updates at the edge and affects `out_req` from the next cycle.
- Reset values:
  - `pend`, `isr`, synchroniser and delay flops: 0.
  - mask: `MASK_RST`.
  - `out_req` 0, `out_code` 2'b00, `out_pending` 0, `out_level` 0.
- Reset during an in-service handler discards all levels and all pending requests.

## Timing
- `out_req`, `out_code` and `out_level` are combinational from registered state only, with no input-to-output path. Exception: `in_ie` gates `out_req` combinationally.
- Edge latency with `SYNC_EN`=1:
  - raw line first sampled high at edge k → `pend` set at edge k+2 → `out_req` high in the cycle after k+2.
  - With `SYNC_EN`=0, `pend` is set at edge k.
- After `in_ack` at edge n, `out_req` drops in the cycle after n, unless a higher source is pending.
- A line held high raises only one request; it must go low for at least one synced sample before it can re-trigger.

## Structure
- A shared package holds the code constants (`IRQ_NONE`=2'b00, `IRQ_1`=2'b01, `IRQ_2`=2'b10, `IRQ_3`=2'b11) and `NUM_SRC`=3. The vector decoder uses the same package.
- One sub-module, `irq_sync_edge`, instantiated 3×: synchroniser (per `SYNC_EN`), delay flop, rising-edge pulse output.
- Priority encode, pending/`isr` update and the ack/eret logic live in the top module.

## Test plan
- Reset then idle: `out_req`=0, `out_code`=00, `out_level`=0, `out_pending`=000 for 10 cycles with `in_irq`=000.
- Raise `in_irq`=001, `in_ie`=1: `out_req`=1 and `out_code`=01 exactly 3 edges later. `in_ack` → `out_level`=1, `out_req`=0, `out_pending`=000.
- Nesting: in service at level 1, raise source 3 → `out_code`=11. Ack → `out_level`=3. Raise source 2 → `out_req` stays 0. `in_eret` → `out_level`=1, then `out_code`=10 and `out_req`=1.
- Mask: write mask 3'b100, raise sources 3 and 1 together → `out_code`=01. Clear mask → `out_code`=11 the next cycle. `out_pending`=101 throughout.
- Simultaneous events:
  - `in_ack` on source 2 in the same cycle as a new edge on source 2 → `pend[2]` stays 1.
  - `in_ack`+`in_eret` together at level 1 with code 11 → `out_level`=3, `isr` bit 1 cleared.
- `in_rst` asserted mid-handler at `out_level`=3 with pending 011 → all outputs 0 next cycle, mask = `MASK_RST`.
